// File: rtl/ptw_if.sv
// ptw_if -- signal bundle between the page-table walker and its environment.
//
// Groups the TLB-miss handshake, the memory read port and the TLB write port.
//   master : environment side (issues misses, answers memory reads)
//   slave  : walker side (accepts misses, issues memory reads, writes the TLB)
//
// Signals
//   miss_valid / miss_pageno / miss_ready : TLB miss request handshake
//   ptbr                                  : level-1 table base (4 KiB aligned)
//   flush                                 : drop the cached level-1 entry
//   mem_req / mem_addr / mem_ack / mem_rdata : memory read port
//   tlb_write / tlb_wrpageno / tlb_tableentry / tlb_wraddr : TLB install port
//   done / fault                          : walk-complete pulse and its qualifier
interface ptw_if;
  logic        miss_valid;
  logic [63:0] miss_pageno;
  logic        miss_ready;
  logic [63:0] ptbr;
  logic        flush;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        tlb_write;
  logic [63:0] tlb_wrpageno;
  logic [63:0] tlb_tableentry;
  logic [12:0] tlb_wraddr;
  logic        done;
  logic        fault;

  modport master (
    output miss_valid, miss_pageno, ptbr, flush, mem_ack, mem_rdata,
    input  miss_ready, mem_req, mem_addr, tlb_write, tlb_wrpageno,
           tlb_tableentry, tlb_wraddr, done, fault
  );

  modport slave (
    input  miss_valid, miss_pageno, ptbr, flush, mem_ack, mem_rdata,
    output miss_ready, mem_req, mem_addr, tlb_write, tlb_wrpageno,
           tlb_tableentry, tlb_wraddr, done, fault
  );
endinterface

// File: rtl/ptw.sv
// ptw -- two-level hardware page-table walker.
//
// On a TLB miss the walker reads the level-1 entry, then the level-2 entry,
// and installs the level-2 entry into a round-robin TLB slot. A not-present
// entry (bit 0 clear) or a page number above 20 bits ends the walk with
// done+fault and no TLB write. All outputs come straight from flops.
//
// Ports
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : ptw_if.slave (miss handshake, memory read port, TLB write port)
//
// Configuration
//   PTW_L1_CACHE_EN : when defined, a single-entry cache of the last present
//                     level-1 entry (tagged by pageno[19:10] and ptbr) lets a
//                     matching miss skip the level-1 read. flush clears it.
module ptw (
  input logic  clk,
  input logic  reset,
  ptw_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    L1    = 3'd1,
    L2    = 3'd2,
    FILL  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t      state_r;
  logic [63:0] pageno_r;
  logic [12:0] victim_r;
  logic        miss_ready_r;
  logic        mem_req_r;
  logic [63:0] mem_addr_r;
  logic        tlb_write_r;
  logic        done_r;
  logic        fault_r;
  logic [63:0] tlb_wrpageno_r;
  logic [63:0] tlb_tableentry_r;
  logic [12:0] tlb_wraddr_r;

  // Level-1 cache hit for the miss currently offered, and the cached table base.
  logic        hit_s;
  logic [51:0] hit_base_s;

  // Address of an 8-byte entry: base + index*8, wrapping modulo 2^64.
  function automatic logic [63:0] pte_addr(input logic [63:0] base, input logic [9:0] idx);
    return base + {51'd0, idx, 3'b000};
  endfunction

`ifdef PTW_L1_CACHE_EN
  logic        c_valid_r;
  logic [9:0]  c_tag_r;
  logic [63:0] c_ptbr_r;
  logic [51:0] c_entry_r;
  logic [63:0] ptbr_r;

  // Tag and table-base compare against the offered miss.
  always_comb begin
    hit_s      = 1'b0;
    hit_base_s = c_entry_r;
    if (c_valid_r && (c_tag_r == bus.miss_pageno[19:10]) && (c_ptbr_r == bus.ptbr)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Cache update: fill on a present level-1 read; flush takes priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_valid_r <= 1'b0;
      c_tag_r   <= 10'd0;
      c_ptbr_r  <= 64'd0;
      c_entry_r <= 52'd0;
      ptbr_r    <= 64'd0;
    end else begin
      if ((state_r == IDLE) && bus.miss_valid) begin
        ptbr_r <= bus.ptbr;
      end
      if (bus.flush) begin
        c_valid_r <= 1'b0;
      end else if ((state_r == L1) && bus.mem_ack && bus.mem_rdata[0]) begin
        c_valid_r <= 1'b1;
        c_tag_r   <= pageno_r[19:10];
        c_ptbr_r  <= ptbr_r;
        c_entry_r <= bus.mem_rdata[63:12];
      end
    end
  end
`else
  // No cache: every walk starts at level 1 and flush has no effect.
  logic unused_flush;
  assign unused_flush = bus.flush;
  assign hit_s        = 1'b0;
  assign hit_base_s   = 52'd0;
`endif

  // Walk state machine; every output is registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r          <= IDLE;
      pageno_r         <= 64'd0;
      victim_r         <= 13'd0;
      miss_ready_r     <= 1'b1;
      mem_req_r        <= 1'b0;
      mem_addr_r       <= 64'd0;
      tlb_write_r      <= 1'b0;
      done_r           <= 1'b0;
      fault_r          <= 1'b0;
      tlb_wrpageno_r   <= 64'd0;
      tlb_tableentry_r <= 64'd0;
      tlb_wraddr_r     <= 13'd0;
    end else begin
      tlb_write_r <= 1'b0;
      done_r      <= 1'b0;
      fault_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.miss_valid) begin
            pageno_r     <= bus.miss_pageno;
            miss_ready_r <= 1'b0;
            if (bus.miss_pageno[63:20] != 44'd0) begin
              // Out-of-range page number: fault without touching memory.
              state_r <= FAULT;
              done_r  <= 1'b1;
              fault_r <= 1'b1;
            end else if (hit_s) begin
              state_r    <= L2;
              mem_req_r  <= 1'b1;
              mem_addr_r <= pte_addr({hit_base_s, 12'h000}, bus.miss_pageno[9:0]);
            end else begin
              state_r    <= L1;
              mem_req_r  <= 1'b1;
              mem_addr_r <= pte_addr(bus.ptbr, bus.miss_pageno[19:10]);
            end
          end else begin
            miss_ready_r <= 1'b1;
          end
        end
        L1: begin
          if (bus.mem_ack) begin
            if (!bus.mem_rdata[0]) begin
              state_r   <= FAULT;
              mem_req_r <= 1'b0;
              done_r    <= 1'b1;
              fault_r   <= 1'b1;
            end else begin
              // mem_req stays high; only the address moves to the level-2 entry.
              state_r    <= L2;
              mem_addr_r <= pte_addr({bus.mem_rdata[63:12], 12'h000}, pageno_r[9:0]);
            end
          end
        end
        L2: begin
          if (bus.mem_ack) begin
            mem_req_r <= 1'b0;
            done_r    <= 1'b1;
            if (!bus.mem_rdata[0]) begin
              state_r <= FAULT;
              fault_r <= 1'b1;
            end else begin
              state_r          <= FILL;
              tlb_write_r      <= 1'b1;
              tlb_wrpageno_r   <= pageno_r;
              tlb_tableentry_r <= bus.mem_rdata;
              tlb_wraddr_r     <= victim_r;
            end
          end
        end
        FILL: begin
          state_r      <= IDLE;
          miss_ready_r <= 1'b1;
          victim_r     <= victim_r + 13'd1;
        end
        FAULT: begin
          state_r      <= IDLE;
          miss_ready_r <= 1'b1;
        end
        default: begin
          state_r      <= IDLE;
          mem_req_r    <= 1'b0;
          miss_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.miss_ready     = miss_ready_r;
  assign bus.mem_req        = mem_req_r;
  assign bus.mem_addr       = mem_addr_r;
  assign bus.tlb_write      = tlb_write_r;
  assign bus.tlb_wrpageno   = tlb_wrpageno_r;
  assign bus.tlb_tableentry = tlb_tableentry_r;
  assign bus.tlb_wraddr     = tlb_wraddr_r;
  assign bus.done           = done_r;
  assign bus.fault          = fault_r;

endmodule

// File: tb/tb_ptw.sv
// tb_ptw -- directed, table-driven bench for the ptw page-table walker.
// Each vector lists the walk, the memory answers and the expected outcome;
// a small responder answers mem_req with per-request wait states.
module tb_ptw;

  logic clk;
  logic reset;
  ptw_if bus ();

  ptw dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] ptbr;
    logic [63:0] pageno;
    logic [1:0]  nreq;
    logic [63:0] addr0;
    logic [63:0] data0;
    logic [63:0] addr1;
    logic [63:0] data1;
    logic [3:0]  w0;
    logic [3:0]  w1;
    logic        fault;
    logic [7:0]  lat;
  } vec_t;

  int          n_cmp;
  int          n_bad;
  logic [12:0] exp_victim;
  vec_t        vecs [8];

  function automatic vec_t mkv(input logic [63:0] ptbr, input logic [63:0] pageno,
                               input int nreq, input logic [63:0] a0, input logic [63:0] d0,
                               input logic [63:0] a1, input logic [63:0] d1,
                               input int w0, input int w1, input bit f, input int lat);
    vec_t v;
    v.ptbr = ptbr;  v.pageno = pageno; v.nreq = 2'(nreq);
    v.addr0 = a0;   v.data0 = d0;      v.addr1 = a1; v.data1 = d1;
    v.w0 = 4'(w0);  v.w1 = 4'(w1);     v.fault = f;  v.lat = 8'(lat);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_victim = 13'd0;
  endtask

  // Runs one walk from a negedge; returns on the negedge after done.
  task automatic run_walk(input vec_t v, input string name);
    int n, ph, wcnt, done_t, n_done, n_tlbw;
    bit pending;
    logic fault_seen;
    logic [63:0] cur_addr;
    n = 0;
    while (bus.miss_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, " miss_ready"}, 64'(bus.miss_ready), 64'd1);
    bus.miss_valid  = 1'b1;
    bus.miss_pageno = v.pageno;
    bus.ptbr        = v.ptbr;
    @(posedge clk);
    #1;
    // Scramble the request inputs: the walker must use its latched copies.
    bus.miss_valid  = 1'b0;
    bus.miss_pageno = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.ptbr        = ~v.ptbr;
    ph = 0; wcnt = 0; pending = 1'b0; cur_addr = 64'd0;
    done_t = 0; n_done = 0; n_tlbw = 0; fault_seen = 1'b0;
    for (int t = 1; t <= 40 && n_done == 0; t++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n_done++;
        done_t = t;
        fault_seen = bus.fault;
      end
      if (bus.tlb_write === 1'b1) begin
        n_tlbw++;
        chk({name, " wrpageno"}, bus.tlb_wrpageno, v.pageno);
        chk({name, " tableentry"}, bus.tlb_tableentry, (v.nreq == 2'd2) ? v.data1 : v.data0);
        chk({name, " wraddr"}, 64'(bus.tlb_wraddr), 64'(exp_victim));
      end
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
      if (bus.mem_req === 1'b1) begin
        if (!pending) begin
          pending  = 1'b1;
          cur_addr = bus.mem_addr;
          wcnt     = (ph == 0) ? int'(v.w0) : int'(v.w1);
          if (ph >= int'(v.nreq)) chk({name, " extra mem_req"}, 64'(ph + 1), 64'(v.nreq));
          else chk({name, " mem_addr"}, bus.mem_addr, (ph == 0) ? v.addr0 : v.addr1);
        end else begin
          chk({name, " mem_addr stable"}, bus.mem_addr, cur_addr);
        end
        if (wcnt == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = (ph == 0) ? v.data0 : v.data1;
          pending       = 1'b0;
          ph++;
        end else begin
          wcnt--;
        end
      end
    end
    chk({name, " done latency"}, 64'(done_t), 64'(v.lat));
    chk({name, " fault"}, 64'(fault_seen), 64'(v.fault));
    chk({name, " mem requests"}, 64'(ph), 64'(v.nreq));
    chk({name, " tlb_write count"}, 64'(n_tlbw), v.fault ? 64'd0 : 64'd1);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk({name, " done one cycle"}, 64'(bus.done), 64'd0);
    chk({name, " tlb_write one cycle"}, 64'(bus.tlb_write), 64'd0);
    chk({name, " mem_req idle"}, 64'(bus.mem_req), 64'd0);
    if (!v.fault) exp_victim = exp_victim + 13'd1;
  endtask

  initial begin
    int nd, nf, nr;
    vec_t va, vb;
    n_cmp = 0; n_bad = 0; exp_victim = 13'd0;
    reset = 1'b0;
    bus.miss_valid = 1'b0; bus.miss_pageno = 64'd0; bus.ptbr = 64'd0; bus.flush = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 64'd0;

    //                ptbr                    pageno                 n  addr0       data0                  addr1       data1                  w0 w1 f  lat
    vecs[0] = mkv(64'h10000,             64'h401,               2, 64'h10008, 64'h20001,             64'h20008, 64'h6001,              0, 0, 0, 3);
    vecs[1] = mkv(64'h10000,             64'h801,               1, 64'h10010, 64'h20000,             64'h0,     64'h0,                 0, 0, 1, 2);
    vecs[2] = mkv(64'h10000,             64'h100000,            0, 64'h0,     64'h0,                 64'h0,     64'h0,                 0, 0, 1, 1);
    vecs[3] = mkv(64'h30000,             64'hC05,               2, 64'h30018, 64'h40001,             64'h40028, 64'h7003,              0, 3, 0, 6);
    vecs[4] = mkv(64'h50000,             64'h1403,              2, 64'h50028, 64'h8001,              64'h8018,  64'h8000,              2, 0, 1, 5);
    vecs[5] = mkv(64'hFFFF_FFFF_FFFF_F000, 64'hFFFFF,           2, 64'hFF8,   64'hFFFF_FFFF_FFFF_F001, 64'hFF8,   64'hDEAD_BEEF_0000_0C01, 0, 0, 0, 3);
    vecs[6] = mkv(64'h10000,             64'h8000_0000_0000_0000, 0, 64'h0,   64'h0,                 64'h0,     64'h0,                 0, 0, 1, 1);
    vecs[7] = mkv(64'h10000,             64'h2C07,              2, 64'h10058, 64'h90001,             64'h90038, 64'h9001,              1, 1, 0, 5);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst tlb_write", 64'(bus.tlb_write), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst fault", 64'(bus.fault), 64'd0);
    chk("rst wrpageno", bus.tlb_wrpageno, 64'd0);
    chk("rst tableentry", bus.tlb_tableentry, 64'd0);
    chk("rst wraddr", 64'(bus.tlb_wraddr), 64'd0);
    chk("rst miss_ready", 64'(bus.miss_ready), 64'd1);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_walk(vecs[i], $sformatf("vec%0d", i));

    // miss_valid held through several walks: each request is taken, none lost.
    bus.miss_valid = 1'b1; bus.miss_pageno = 64'h100000; bus.ptbr = 64'h0;
    @(posedge clk);
    nd = 0; nf = 0; nr = 0;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      if (bus.done === 1'b1) nd++;
      if (bus.fault === 1'b1) nf++;
      if (bus.mem_req === 1'b1) nr++;
    end
    bus.miss_valid = 1'b0;
    chk("hold done count", 64'(nd), 64'd3);
    chk("hold fault count", 64'(nf), 64'd3);
    chk("hold mem_req count", 64'(nr), 64'd0);
    chk("hold ready", 64'(bus.miss_ready), 64'd1);
    @(negedge clk);
    chk("hold done quiet", 64'(bus.done), 64'd0);

    // Reset while the level-2 read is outstanding.
    bus.miss_valid = 1'b1; bus.miss_pageno = 64'h401; bus.ptbr = 64'h10000;
    @(posedge clk);
    #1 bus.miss_valid = 1'b0;
    @(negedge clk);
    chk("rmid L1 req", 64'(bus.mem_req), 64'd1);
    chk("rmid L1 addr", bus.mem_addr, 64'h10008);
    bus.mem_ack = 1'b1; bus.mem_rdata = 64'h20001;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("rmid L2 addr", bus.mem_addr, 64'h20008);
    @(negedge clk);
    chk("rmid L2 waiting", 64'(bus.mem_req), 64'd1);
    reset = 1'b0;
    #1;
    chk("rmid mem_req drop", 64'(bus.mem_req), 64'd0);
    chk("rmid done", 64'(bus.done), 64'd0);
    chk("rmid wraddr", 64'(bus.tlb_wraddr), 64'd0);
    chk("rmid ready", 64'(bus.miss_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    nd = 0; nr = 0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.tlb_write === 1'b1) nd++;
      if (bus.mem_req === 1'b1) nr++;
    end
    chk("rmid no done", 64'(nd), 64'd0);
    chk("rmid no req", 64'(nr), 64'd0);
    exp_victim = 13'd0;
    run_walk(vecs[0], "post-reset");

`ifdef PTW_L1_CACHE_EN
    do_reset();
    run_walk(vecs[0], "cache fill");
    run_walk(mkv(64'h10000, 64'h402, 1, 64'h20010, 64'h6002, 64'h0, 64'h0, 0, 0, 0, 2), "cache hit");
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    run_walk(mkv(64'h10000, 64'h402, 2, 64'h10008, 64'h20001, 64'h20010, 64'h6002, 0, 0, 0, 3), "after flush");
`endif

    // Victim counter through a full wrap: slots 0..8191 then 0.
    do_reset();
    va = mkv(64'h10000, 64'h401, 2, 64'h10008, 64'h20001, 64'h20008, 64'h6001, 0, 0, 0, 3);
    vb = mkv(64'h10000, 64'h801, 2, 64'h10010, 64'h20001, 64'h20008, 64'h6001, 0, 0, 0, 3);
    for (int i = 0; i < 8193; i++) begin
      if (i % 2 == 0) run_walk(va, "wrap");
      else run_walk(vb, "wrap");
    end
    chk("wrap final slot", 64'(bus.tlb_wraddr), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ptw.md
PTW -- requirements
Module: ptw

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, release is synchronous to clk.
REQ-003 miss_valid  input  1  TLB miss request.
REQ-004 miss_pageno  input  64  virtual page number that missed.
REQ-005 miss_ready  output  1  walker can accept a miss.
REQ-006 ptbr  input  64  level-1 table base, 4 KiB aligned; sampled at miss accept.
REQ-007 flush  input  1  invalidate the cached level-1 entry.
REQ-008 mem_req  output  1  memory read request.
REQ-009 mem_addr  output  64  memory read address, 8-byte aligned.
REQ-010 mem_ack  input  1  read complete.
REQ-011 mem_rdata  input  64  read data; valid only in the mem_ack cycle.
REQ-012 tlb_write  output  1  one-cycle TLB write strobe.
REQ-013 tlb_wrpageno  output  64  page number to install.
REQ-014 tlb_tableentry  output  64  page table entry to install.
REQ-015 tlb_wraddr  output  13  TLB slot to write.
REQ-016 done  output  1  one-cycle walk-complete pulse.
REQ-017 fault  output  1  qualifies done; 1 = no translation installed.

Function
REQ-018 States: IDLE, L1, L2, FILL, FAULT; miss_ready = (state == IDLE).
REQ-019 Accept on miss_valid && miss_ready: latch miss_pageno and ptbr; go to L1, or to FAULT if miss_pageno[63:20] != 0.
REQ-020 L1: mem_req=1, mem_addr = ptbr + {miss_pageno[19:10], 3'b000}; stay in L1 until mem_ack.
REQ-021 On L1 ack: if mem_rdata[0]=0 go to FAULT; else latch the entry and go to L2.
REQ-022 L2: mem_req=1, mem_addr = {l1entry[63:12], 12'h0} + {miss_pageno[9:0], 3'b000}; stay in L2 until mem_ack.
REQ-023 On L2 ack: if mem_rdata[0]=0 go to FAULT; else latch the entry and go to FILL.
REQ-024 FILL (one cycle): tlb_write=1, done=1, fault=0, tlb_wrpageno = latched pageno, tlb_tableentry = latched L2 entry, tlb_wraddr = victim counter; then IDLE.
REQ-025 FAULT (one cycle): done=1, fault=1, tlb_write=0; then IDLE.
REQ-026 Victim counter: 13-bit round-robin; increments after each FILL; wraps 8191 -> 0.
REQ-027 mem_req and mem_addr are driven from registered state only; mem_addr stays stable while mem_req is high.
REQ-028 In IDLE, FILL and FAULT: mem_req=0; mem_ack is ignored.
REQ-029 Latency with zero-wait ack and no cache hit: accept at edge N, done at cycle N+3; each wait cycle adds one.
REQ-030 A miss_valid arriving during a walk is held off by miss_ready=0; it is never dropped.
REQ-031 Address adds are 64-bit modulo 2^64; carries out of bit 63 are discarded.

Reset
REQ-032 Reset asserted: state=IDLE, victim counter=0, L1 cache invalid, latches=0.
REQ-033 Reset asserted: mem_req, tlb_write, done and fault are 0; tlb_wrpageno, tlb_tableentry and tlb_wraddr are 0.
REQ-034 Reset mid-walk abandons the walk: no tlb_write, no done.

Configuration
REQ-035 The L1 entry cache is compiled in only when PTW_L1_CACHE_EN is defined.
REQ-036 With PTW_L1_CACHE_EN: on a present L1 ack, store the entry, tag miss_pageno[19:10] and ptbr, and set valid.
REQ-037 With PTW_L1_CACHE_EN: an accept that matches tag and ptbr while valid goes straight to L2, giving done at N+2.
REQ-038 With PTW_L1_CACHE_EN: flush clears valid at the next edge and wins over a same-cycle cache fill.
REQ-039 Without PTW_L1_CACHE_EN: no cache state exists, flush is ignored, and every walk enters L1.

Verification
REQ-040 ptbr=0x10000, pageno=0x401, zero-wait acks: L1 addr 0x10008 returns 0x20001 -> L2 addr 0x20008 returns 0x6001 -> tlb_write with wrpageno=0x401, tableentry=0x6001, wraddr=0, done at N+3, fault=0.
REQ-041 L1 data 0x20000 (not present) -> single done with fault=1, no L2 request, no tlb_write.
REQ-042 pageno=0x100000 -> FAULT with no mem_req; done and fault at N+1.
REQ-043 mem_ack delayed 3 cycles in L2 -> mem_req and mem_addr held stable; done at N+6.
REQ-044 8193 successful walks -> wraddr sequence 0..8191 then 0.
REQ-045 With PTW_L1_CACHE_EN: repeat pageno=0x402 after REQ-040 -> only L2 addr 0x20010 requested, done at N+2; after flush -> L1 requested again. Reset asserted during L2 -> mem_req falls immediately, no done.
